// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver that packs every four bytes big-endian into a 32-bit word
// and appends the word to a block-RAM input buffer with a registered read port.
module uart_word_receiver #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 1024,
  parameter int LOG_DEPTH   = 10
) (
  input  logic                 CLK,
  input  logic                 INITIALIZE,
  input  logic                 UART_RX,
  input  logic [LOG_DEPTH-1:0] rd_index,
  output logic [31:0]          rd_data,
  output logic [LOG_DEPTH:0]   valid_num,
  output logic                 framing_err,
  output logic                 overflow
);

  localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_PER_BIT / 2);
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLK_PER_BIT - 1);
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic                 rx_meta, rx_s;
  logic [BW-1:0]        baud_cnt;
  logic                 baud_zero;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift_reg;
  logic [1:0]           byte_cnt;
  logic [31:0]          word;
  logic                 commit;
  logic                 wr_en;
  logic [LOG_DEPTH-1:0] wr_addr;
  logic [31:0]          mem [DEPTH];

  logic load_half, load_full, clear_bits, count_down, sample_bit, byte_ok, frame_bad;

  assign baud_zero = (baud_cnt == '0);

  // Sync flops reset to the idle level so no false start follows reset.
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (baud_zero) state_next = rx_s ? IDLE : DATA;
      DATA:      if (baud_zero && bit_cnt == 3'd7) state_next = STOP;
      STOP:      if (baud_zero) state_next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    clear_bits = 1'b0;
    count_down = 1'b0;
    sample_bit = 1'b0;
    byte_ok    = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE:  load_half = !rx_s;
      START: begin
        if (baud_zero) begin
          load_full  = !rx_s;
          clear_bits = !rx_s;
        end else begin
          count_down = 1'b1;
        end
      end
      DATA: begin
        if (baud_zero) begin
          sample_bit = 1'b1;
          load_full  = 1'b1;
        end else begin
          count_down = 1'b1;
        end
      end
      STOP: begin
        if (baud_zero) begin
          byte_ok   = rx_s;
          frame_bad = !rx_s;
        end else begin
          count_down = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      byte_cnt    <= '0;
      word        <= '0;
      commit      <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (load_half)       baud_cnt <= BAUD_HALF;
      else if (load_full)  baud_cnt <= BAUD_FULL;
      else if (count_down) baud_cnt <= baud_cnt - BW'(1);

      if (clear_bits)      bit_cnt <= '0;
      else if (sample_bit) bit_cnt <= bit_cnt + 3'd1;

      if (sample_bit) shift_reg <= {rx_s, shift_reg[7:1]};

      // Shifting bytes in from the bottom leaves the first byte in the MSB after four.
      if (byte_ok) begin
        word     <= {word[23:0], shift_reg};
        byte_cnt <= byte_cnt + 2'd1;
      end
      commit <= byte_ok && (byte_cnt == 2'd3);

      if (frame_bad) framing_err <= 1'b1;
    end
  end

  assign wr_en   = commit && (valid_num < FULL_COUNT);
  assign wr_addr = valid_num[LOG_DEPTH-1:0];

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      valid_num <= '0;
      overflow  <= 1'b0;
    end else if (commit) begin
      if (valid_num < FULL_COUNT) valid_num <= valid_num + (LOG_DEPTH + 1)'(1);
      else                        overflow  <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= word;
  end

  // Bypass makes a read of the address being written return the new word.
  always_ff @(posedge CLK) begin
    if (INITIALIZE)                        rd_data <= '0;
    else if (wr_en && rd_index == wr_addr) rd_data <= word;
    else                                   rd_data <= mem[rd_index];
  end

endmodule

// File: doc/uart_word_receiver.md
Name: uart_word_receiver

Overview:
- Upstream input stage for the CPU's READI/READF path.
- Deserialises 8N1 UART bytes from UART_RX and packs every 4 bytes big-endian into a 32-bit word.
- Appends each word to an internal input buffer and exports the running valid-word count.
- The CPU compares its read index against valid_num, stalls while the buffer is empty, and fetches words through a registered read port.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- DEPTH, 1024, buffer capacity in 32-bit words.
- LOG_DEPTH, 10, log2(DEPTH).

Ports:
- CLK  in  1  system clock.
- INITIALIZE  in  1  synchronous active-high reset.
- UART_RX  in  1  asynchronous serial input, idle high.
- rd_index  in  LOG_DEPTH  word index to read.
- rd_data  out  32  buffer[rd_index], registered.
- valid_num  out  LOG_DEPTH+1  words written so far; buffer[0 .. valid_num) is valid.
- framing_err  out  1  sticky: a stop bit was sampled low.
- overflow  out  1  sticky: a word arrived while valid_num == DEPTH.

Behaviour:
- Clock and reset: single clock CLK. INITIALIZE is sampled on the CLK edge only (synchronous, active-high).
- Reset values: valid_num=0, rd_data=0, framing_err=0, overflow=0, FSM=IDLE, byte counter=0, bit counter=0, baud counter=0, partial word cleared. Buffer contents are not cleared.
- Reset mid-byte or mid-word aborts reception. Partial bytes and words are discarded.
- Input sync: UART_RX passes through a 2-flop synchroniser. The synchronised signal is rx_s; all decisions use rx_s.
- State IDLE:
  - Stay while rx_s=1.
  - On rx_s=0, load baud counter with CLK_PER_BIT/2 (integer divide) and go to START.
- State START:
  - Count down to 0, then re-sample rx_s.
  - rx_s=0: go to DATA, bit counter=0, baud counter=CLK_PER_BIT-1.
  - rx_s=1: glitch. Return to IDLE; nothing is recorded.
- State DATA:
  - Sample rx_s each time the baud counter hits 0, then reload CLK_PER_BIT-1.
  - Bits arrive LSB first into the shift register. After 8 samples go to STOP.
- State STOP:
  - Sample rx_s at the bit centre.
  - rx_s=1: byte accepted, return to IDLE.
  - rx_s=0: set framing_err, discard the byte (byte counter unchanged), go to WAIT_HIGH.
- State WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break or low line from being read as a start bit.
- Word packing:
  - Accepted byte k (k=0..3) goes to word bits [31-8k : 24-8k]; the first byte is the MSB.
  - The byte counter wraps from 3 to 0.
- Word commit, in the cycle after the 4th byte is accepted:
  - If valid_num < DEPTH: write buffer[valid_num[LOG_DEPTH-1:0]] <= word and increment valid_num.
  - If valid_num == DEPTH: drop the word, set overflow; valid_num holds at DEPTH and never wraps.
- Visibility: a new word is readable at rd_index = old valid_num no later than the cycle valid_num increments.
  - If rd_index equals the write address on the write cycle, rd_data returns the new word (write-first).
- Read port: rd_data <= buffer[rd_index] every cycle, 1-cycle latency, no enable. The buffer maps to block RAM.
- Latency: valid_num increments 2 cycles after the stop-bit centre sample of the 4th byte (stop sample, then commit register).
- framing_err and overflow are cleared only by INITIALIZE.

Test Plan:
- Bench uses CLK_PER_BIT=16, DEPTH=4, LOG_DEPTH=2 unless noted.
- Single word: send bytes 0x12,0x34,0x56,0x78. Required: valid_num 0->1; rd_index=0 gives rd_data=0x12345678 one cycle later; framing_err=0.
- Glitch rejection: drive UART_RX low for 4 cycles, then high, then send 0xDE,0xAD,0xBE,0xEF. Required: exactly one word 0xDEADBEEF; valid_num=1.
- Framing error: send 0xAA with the stop bit low, hold low for 100 cycles, release, then send 0x01,0x02,0x03,0x04. Required: framing_err=1; word=0x01020304; 0xAA discarded.
- Overflow: send 5 words 0x00000001..0x00000005. Required: valid_num=4, overflow=1, buffer[3]=0x00000004, word 5 absent.
- Reset mid-word: send 0x11,0x22, assert INITIALIZE for 1 cycle, then send 0xA0,0xB0,0xC0,0xD0. Required: valid_num=1, buffer[0]=0xA0B0C0D0, all flags 0.
- Back-to-back reads: with 3 words loaded (0x1,0x2,0x3), sweep rd_index 0,1,2 on consecutive cycles. Required: rd_data 0x1,0x2,0x3 on the following cycles, each 1-cycle delayed.
